// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_pkg                                                        |
// | Brief    : Shared types and constants for the data-memory responder.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package dmem_pkg;

    localparam int c_CNT_W           = 4;
    localparam int c_DEF_LATENCY     = 2;
    localparam int c_DEF_DEPTH_WORDS = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int addr_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_array                                                      |
// | Brief    : Single-port synchronous word RAM with registered read data.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = c_DEF_DEPTH_WORDS,
    parameter int AW          = addr_width(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        rdata <= r_mem[idx];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_responder                                                  |
// | Brief    : Fixed-latency load/store responder with valid/ready handshake. |
// |            Optional misalignment flag via DMEM_ALIGN_CHECK_EN.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = c_DEF_DEPTH_WORDS,
    parameter int LATENCY     = c_DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int                 c_AW       = addr_width(DEPTH_WORDS);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_ready, r_rsp_valid, r_rsp_load, r_rsp_err;
    logic               r_write, r_misal;
    logic [c_AW-1:0]    r_idx;
    logic [31:0]        r_wdata;

    logic               w_accept, w_enter_resp, w_req_misal, w_we;
    logic               w_op_write, w_op_misal;
    logic [c_AW-1:0]    w_op_idx;
    logic [31:0]        w_op_wdata, w_arr_rdata;
    logic               w_unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_req_misal   = (req_addr[1:0] != 2'b00);
    assign w_unused_addr = ^req_addr[31:c_AW+2];
`else
    assign w_req_misal   = 1'b0;
    assign w_unused_addr = ^{req_addr[31:c_AW+2], req_addr[1:0]};
`endif

    assign w_accept = req_valid && r_ready;

    // With single-cycle latency RESP is entered at the accept edge, so the array sees the live request.
    if (LATENCY == 1) begin : g_lat_one
        assign w_op_write = req_write;
        assign w_op_misal = w_req_misal;
        assign w_op_idx   = req_addr[c_AW+1:2];
        assign w_op_wdata = req_wdata;
    end else begin : g_lat_multi
        assign w_op_write = r_write;
        assign w_op_misal = r_misal;
        assign w_op_idx   = r_idx;
        assign w_op_wdata = r_wdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_nxt == RESP);
    assign w_we         = rst_n && w_enter_resp && w_op_write && !w_op_misal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_load  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_write     <= 1'b0;
            r_misal     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= (w_state_nxt != WAIT);
            r_rsp_valid <= w_enter_resp;
            r_rsp_load  <= w_enter_resp && !w_op_write && !w_op_misal;
            r_rsp_err   <= w_enter_resp && w_op_misal;
            if (w_accept) begin
                r_write <= req_write;
                r_misal <= w_req_misal;
                r_idx   <= req_addr[c_AW+1:2];
                r_wdata <= req_wdata;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (c_AW)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .idx   (w_op_idx),
        .wdata (w_op_wdata),
        .rdata (w_arr_rdata)
    );

    // Read data is qualified by a registered strobe so it is zero outside load responses.
    assign rsp_rdata = w_arr_rdata & {32{r_rsp_load}};
    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign busy      = (r_state != IDLE);
`ifdef DMEM_ALIGN_CHECK_EN
    assign rsp_err   = r_rsp_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                               |
// | Brief    : Self-checking bench over five latencies with a cycle model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam int c_NI = 5;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            default: return 15;
        endcase
    endfunction

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [c_NI-1:0] r_valid = '0;
    logic            r_write = 1'b0;
    logic [31:0]     r_addr = '0;
    logic [31:0]     r_wdata = '0;
    logic [c_NI-1:0] w_ready, w_rsp_valid, w_busy, w_err;
    logic [31:0]     w_rdata [c_NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (256),
            .LATENCY     (lat_of(g))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (r_valid[g]),
            .req_write (r_write),
            .req_addr  (r_addr),
            .req_wdata (r_wdata),
            .req_ready (w_ready[g]),
            .rsp_valid (w_rsp_valid[g]),
            .rsp_rdata (w_rdata[g]),
            .busy      (w_busy[g])
`ifdef DMEM_ALIGN_CHECK_EN
            ,
            .rsp_err   (w_err[g])
`endif
        );
    end
`ifndef DMEM_ALIGN_CHECK_EN
    assign w_err = '0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding request, response due LATENCY cycles after accept.
    int          act = 1;
    bit          m_rst = 1'b1;
    bit          m_pend = 1'b0;
    int          m_left = 0;
    bit          m_w = 1'b0;
    bit          m_err = 1'b0;
    logic [7:0]  m_idx = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_mem [c_NI][256];
    bit          m_known [c_NI][256];

    always @(negedge clk) begin
        bit e_rsp, e_busy, e_ready, e_errb;
        if (m_rst) begin
            e_rsp = 1'b0; e_busy = 1'b0; e_ready = 1'b0; e_errb = 1'b0;
        end else begin
            e_rsp   = m_pend && (m_left == 1);
            e_busy  = m_pend;
            e_ready = !m_pend || (m_left == 1);
            e_errb  = e_rsp && m_err;
        end
        check("mon_ready", 32'(w_ready[act]), 32'(e_ready));
        check("mon_rsp_valid", 32'(w_rsp_valid[act]), 32'(e_rsp));
        check("mon_busy", 32'(w_busy[act]), 32'(e_busy));
`ifdef DMEM_ALIGN_CHECK_EN
        check("mon_rsp_err", 32'(w_err[act]), 32'(e_errb));
`endif
        if (e_rsp && !m_w && !m_err) begin
            if (m_known[act][m_idx]) check("mon_rdata", w_rdata[act], m_mem[act][m_idx]);
        end else begin
            check("mon_rdata_zero", w_rdata[act], 32'h0);
        end
        if (e_rsp) begin
            if (m_w && !m_err) begin
                m_mem[act][m_idx]   = m_wdata;
                m_known[act][m_idx] = 1'b1;
            end
            m_pend = 1'b0;
        end else if (m_pend) begin
            m_left--;
        end
        if (!rst_n) begin
            m_rst  = 1'b1;
            m_pend = 1'b0;
        end else begin
            m_rst = 1'b0;
            if (r_valid[act] && e_ready) begin
                m_pend  = 1'b1;
                m_left  = lat_of(act);
                m_w     = r_write;
                m_idx   = r_addr[9:2];
                m_wdata = r_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
                m_err   = (r_addr[1:0] != 2'b00);
`else
                m_err   = 1'b0;
`endif
            end
        end
    end

    task automatic drive(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
        r_write    = w;
        r_addr     = a;
        r_wdata    = d;
        r_valid[k] = 1'b1;
    endtask

    // Returns 3 time units after the accepting edge.
    task automatic wait_accept(input int k);
        int n = 0;
        @(negedge clk);
        while (!w_ready[k] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!w_ready[k]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready 0 expected 1 on inst %0d", k);
        end
        @(posedge clk);
        #3;
    endtask

    task automatic do_req(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output bit er);
        drive(k, w, a, d);
        wait_accept(k);
        r_valid[k] = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (w_rsp_valid[k]) begin
                lat = n;
                rd  = w_rdata[k];
                er  = w_err[k];
                break;
            end
        end
        @(posedge clk);
        #3;
    endtask

    typedef struct {
        int          k;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vt [8];
        logic [31:0] rd;
        int          lat;
        bit          er;

        vt[0] = '{1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vt[2] = '{0, 1'b1, 32'h30, 32'h00C0FFEE, 32'h0};
        vt[3] = '{0, 1'b0, 32'h30, 32'h0,        32'h00C0FFEE};
        vt[4] = '{2, 1'b1, 32'h44, 32'h00000003, 32'h0};
        vt[5] = '{2, 1'b0, 32'h44, 32'h0,        32'h00000003};
        vt[6] = '{4, 1'b1, 32'h08, 32'h0000F00D, 32'h0};
        vt[7] = '{4, 1'b0, 32'h08, 32'h0,        32'h0000F00D};

        // Reset state
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", 32'(w_ready[1]), 32'h0);
            check("rst_busy", 32'(w_busy[1]), 32'h0);
            check("rst_rsp_valid", 32'(w_rsp_valid[1]), 32'h0);
            check("rst_rdata", w_rdata[1], 32'h0);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #3;
        @(negedge clk);
        check("ready_after_reset", 32'(w_ready[1]), 32'h1);
        @(posedge clk); #3;

        // Directed table over several latencies
        for (int i = 0; i < 8; i++) begin
            act = vt[i].k;
            do_req(vt[i].k, vt[i].w, vt[i].a, vt[i].d, rd, lat, er);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(lat_of(vt[i].k)));
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
        end

        // Back-to-back store/load with address wrap, LATENCY=2
        act = 1;
        drive(1, 1'b1, 32'h400, 32'h1234);
        wait_accept(1);
        drive(1, 1'b0, 32'h000, 32'h0);
        @(negedge clk);
        check("b2b_wait_busy", 32'(w_busy[1]), 32'h1);
        check("b2b_wait_ready", 32'(w_ready[1]), 32'h0);
        @(negedge clk);
        check("b2b_store_rsp", 32'(w_rsp_valid[1]), 32'h1);
        check("b2b_resp_ready", 32'(w_ready[1]), 32'h1);
        @(posedge clk); #3;
        r_valid[1] = 1'b0;
        @(negedge clk);
        check("b2b_no_idle", 32'(w_busy[1]), 32'h1);
        @(negedge clk);
        check("b2b_load_rsp", 32'(w_rsp_valid[1]), 32'h1);
        check("b2b_load_data", w_rdata[1], 32'h1234);
        @(posedge clk); #3;

        // Reset two cycles after accepting a store, LATENCY=4
        act = 3;
        do_req(3, 1'b1, 32'h20, 32'h1111, rd, lat, er);
        drive(3, 1'b1, 32'h20, 32'hAAAA);
        wait_accept(3);
        r_valid[3] = 1'b0;
        @(posedge clk); #3;
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(posedge clk); #3;
        @(negedge clk);
        check("midrst_ready", 32'(w_ready[3]), 32'h0);
        check("midrst_busy", 32'(w_busy[3]), 32'h0);
        check("midrst_rsp_valid", 32'(w_rsp_valid[3]), 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #3;
        do_req(3, 1'b0, 32'h20, 32'h0, rd, lat, er);
        check("midrst_load_old", rd, 32'h1111);

        // Misaligned store to 0x22
        act = 1;
        do_req(1, 1'b1, 32'h20, 32'h9999, rd, lat, er);
        do_req(1, 1'b1, 32'h22, 32'h55, rd, lat, er);
        check("misal_latency", 32'(lat), 32'h2);
`ifdef DMEM_ALIGN_CHECK_EN
        check("misal_err", 32'(er), 32'h1);
        do_req(1, 1'b0, 32'h20, 32'h0, rd, lat, er);
        check("misal_word_kept", rd, 32'h9999);
        check("aligned_no_err", 32'(er), 32'h0);
`else
        do_req(1, 1'b0, 32'h20, 32'h0, rd, lat, er);
        check("misal_word_written", rd, 32'h55);
`endif

        // Randomized traffic on every latency, checked by the model
        for (int k = 0; k < c_NI; k++) begin
            act = k;
            for (int i = 0; i < 30; i++) begin
                logic [31:0] a;
                a = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2);
                if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
                drive(k, 1'($urandom_range(0, 1)), a, $urandom());
                wait_accept(k);
                r_valid[k] = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #3;
                end
            end
            repeat (20) begin
                @(posedge clk); #3;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
